// File: rtl/frame_fifo_write_nb_pkg.sv
// Shared types and default sizing for the frame-to-SDRAM burst writer.
// The state encoding lives here so the bench and any wrapper agree on it.
package frame_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK   = 3'd1,
        WAIT  = 3'd2,
        BURST = 3'd3,
        DONE  = 3'd4
    } frame_state_t;

    localparam int ADDR_W_DEF    = 23;
    localparam int LEN_W_DEF     = 23;
    localparam int BURST_W_DEF   = 10;
    localparam int BURST_MAX_DEF = 256;
    localparam int NBUF_DEF      = 4;
    localparam int IDX_W_DEF     = 2;
    localparam int CNT_W_DEF     = 16;
    localparam int ACLR_MIN_DEF  = 4;

    // Operands are zero-extended by the caller so one function serves all widths.
    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_fifo_write_nb_if.sv
// Burst request bus between the frame writer (master) and the SDRAM burst
// controller (slave).
interface frame_fifo_write_nb_if
    import frame_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) ();

    logic               wr_burst_req;
    logic [BURST_W-1:0] wr_burst_len;
    logic [ADDR_W-1:0]  wr_burst_addr;
    logic               wr_burst_data_req;
    logic               wr_burst_finish;

    modport master (
        output wr_burst_req,
        output wr_burst_len,
        output wr_burst_addr,
        input  wr_burst_data_req,
        input  wr_burst_finish
    );

    modport slave (
        input  wr_burst_req,
        input  wr_burst_len,
        input  wr_burst_addr,
        output wr_burst_data_req,
        output wr_burst_finish
    );

endinterface

// File: rtl/frame_fifo_write_nb_addr_sel.sv
// Picks one frame-buffer base address out of the packed address vector.
// An index beyond NBUF-1 (non power-of-two NBUF) yields address 0.
module frame_addr_sel
    import frame_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NBUF   = NBUF_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic [NBUF*ADDR_W-1:0] i_write_addr,
    input  logic [IDX_W-1:0]       i_index,
    output logic [ADDR_W-1:0]      o_base_addr
);

    always_comb begin
        o_base_addr = '0;
        for (int k = 0; k < NBUF; k++) begin
            if (i_index == IDX_W'(k)) begin
                o_base_addr = i_write_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/frame_fifo_write_nb.sv
// Drains the pixel FIFO into one of NBUF SDRAM frame buffers as a series of
// bursts of up to BURST_MAX words, with optional buffer rotation and abort.
//
// state | meaning
// IDLE  | waiting for write_req
// ACK   | acknowledging request, holding the FIFO in clear
// WAIT  | waiting for enough FIFO words for the next burst
// BURST | burst request outstanding at the SDRAM controller
// DONE  | frame complete, finish pulse, optional index rotate
module frame_fifo_write_nb
    import frame_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int BURST_W   = BURST_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int NBUF      = NBUF_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ACLR_MIN  = ACLR_MIN_DEF
) (
    input  logic                   mem_clk,
    input  logic                   rst,
    input  logic                   write_req,
    output logic                   write_req_ack,
    output logic                   write_finish,
    output logic                   write_aborted,
    input  logic                   frame_abort,
    input  logic                   auto_index,
    input  logic [NBUF*ADDR_W-1:0] write_addr,
    input  logic [IDX_W-1:0]       write_addr_index,
    input  logic [LEN_W-1:0]       write_len,
    output logic [IDX_W-1:0]       cur_index,
    output logic                   busy,
    output logic                   fifo_aclr,
    input  logic [CNT_W-1:0]       rd_data_count,
    frame_fifo_write_nb_if.master  bus
);

    localparam int ACW = $clog2(ACLR_MIN + 1);

    frame_state_t       r_state;
    logic [LEN_W-1:0]   r_remain;
    logic [ADDR_W-1:0]  r_addr;
    logic [IDX_W-1:0]   r_index;
    logic [IDX_W-1:0]   r_cur_index;
    logic [ACW-1:0]     r_aclr_cnt;
    logic               r_abort_pend;
    logic [BURST_W-1:0] r_blen;
    logic [BURST_W:0]   r_dreq_cnt;
    logic               r_ack;
    logic               r_aclr;
    logic               r_finish;
    logic               r_aborted;
    logic               r_breq;
    logic               r_busy;

    logic [IDX_W-1:0]   w_sel_index;
    logic [ADDR_W-1:0]  w_base_addr;
    logic [31:0]        w_blen_full;
    logic [BURST_W-1:0] w_blen;
    logic               w_fifo_ready;

    assign w_sel_index  = auto_index ? r_index : write_addr_index;
    assign w_blen_full  = min_len(32'(BURST_MAX), 32'(r_remain));
    assign w_blen       = w_blen_full[BURST_W-1:0];
    assign w_fifo_ready = (32'(rd_data_count) >= w_blen_full);

    frame_addr_sel #(
        .ADDR_W (ADDR_W),
        .NBUF   (NBUF),
        .IDX_W  (IDX_W)
    ) u_addr_sel (
        .i_write_addr (write_addr),
        .i_index      (w_sel_index),
        .o_base_addr  (w_base_addr)
    );

    always_ff @(posedge mem_clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_remain     <= '0;
            r_addr       <= '0;
            r_index      <= '0;
            r_cur_index  <= '0;
            r_aclr_cnt   <= '0;
            r_abort_pend <= 1'b0;
            r_blen       <= '0;
            r_dreq_cnt   <= '0;
            r_ack        <= 1'b0;
            r_aclr       <= 1'b0;
            r_finish     <= 1'b0;
            r_aborted    <= 1'b0;
            r_breq       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_finish  <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (write_req) begin
                        r_remain     <= write_len;
                        r_cur_index  <= w_sel_index;
                        r_addr       <= w_base_addr;
                        r_aclr_cnt   <= ACW'(ACLR_MIN - 1);
                        r_abort_pend <= 1'b0;
                        r_ack        <= 1'b1;
                        r_aclr       <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ACK;
                    end
                end
                ACK: begin
                    if (frame_abort) begin
                        r_ack     <= 1'b0;
                        r_aclr    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_aclr_cnt == '0 && !write_req) begin
                        r_ack   <= 1'b0;
                        r_aclr  <= 1'b0;
                        r_state <= WAIT;
                    end else if (r_aclr_cnt != '0) begin
                        r_aclr_cnt <= r_aclr_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (frame_abort) begin
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_remain == '0) begin
                        r_finish <= 1'b1;
                        r_state  <= DONE;
                    end else if (w_fifo_ready) begin
                        r_blen     <= w_blen;
                        r_dreq_cnt <= '0;
                        r_breq     <= 1'b1;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (frame_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (bus.wr_burst_data_req) begin
                        r_dreq_cnt <= r_dreq_cnt + 1'b1;
                    end
                    if (bus.wr_burst_finish) begin
                        // blen never exceeds remain, so remain cannot underflow
                        r_addr   <= r_addr + ADDR_W'(r_blen);
                        r_remain <= r_remain - LEN_W'(r_blen);
                        r_breq   <= 1'b0;
                        if (r_abort_pend || frame_abort) begin
                            r_busy    <= 1'b0;
                            r_aborted <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                DONE: begin
                    if (auto_index) begin
                        r_index <= (r_index == IDX_W'(NBUF - 1)) ? '0 : r_index + 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign write_req_ack     = r_ack;
    assign fifo_aclr         = r_aclr;
    assign write_finish      = r_finish;
    assign write_aborted     = r_aborted;
    assign busy              = r_busy;
    assign cur_index         = r_cur_index;
    assign bus.wr_burst_req  = r_breq;
    assign bus.wr_burst_len  = r_blen;
    assign bus.wr_burst_addr = r_addr;

    // The controller must have popped exactly one FIFO word per burst word.
    a_dreq_count: assert property (@(posedge mem_clk) disable iff (!rst)
        (r_state == BURST && bus.wr_burst_finish) |->
        ((r_dreq_cnt + (BURST_W+1)'(bus.wr_burst_data_req)) == {1'b0, r_blen}));

endmodule

// File: tb/tb_frame_fifo_write_nb.sv
// Bench for frame_fifo_write_nb: an SDRAM controller model checks each burst
// against a queue of bursts predicted when the frame request is issued.
module tb_frame_fifo_write_nb;
    import frame_pkg::*;

    localparam int AW   = 23;
    localparam int LW   = 23;
    localparam int BMAX = 256;
    localparam int NB   = 4;

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
    } burst_t;

    logic          mem_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_req = 1'b0;
    logic          write_req_ack, write_finish, write_aborted;
    logic          abort_main = 1'b0;
    logic          abort_srv = 1'b0;
    logic          frame_abort;
    logic          auto_index = 1'b0;
    logic [NB*AW-1:0] write_addr;
    logic [1:0]    write_addr_index = '0;
    logic [LW-1:0] write_len = '0;
    logic [1:0]    cur_index;
    logic          busy, fifo_aclr;
    logic [15:0]   rd_data_count = 16'd1024;

    int n_compared = 0;
    int n_mismatched = 0;
    int model_idx = 0;
    int burst_seq = 0;
    int abort_at = -1;
    burst_t sb_q[$];

    frame_fifo_write_nb_if bus ();

    assign frame_abort = abort_main | abort_srv;

    frame_fifo_write_nb dut (
        .mem_clk          (mem_clk),
        .rst              (rst_n),
        .write_req        (write_req),
        .write_req_ack    (write_req_ack),
        .write_finish     (write_finish),
        .write_aborted    (write_aborted),
        .frame_abort      (frame_abort),
        .auto_index       (auto_index),
        .write_addr       (write_addr),
        .write_addr_index (write_addr_index),
        .write_len        (write_len),
        .cur_index        (cur_index),
        .busy             (busy),
        .fifo_aclr        (fifo_aclr),
        .rd_data_count    (rd_data_count),
        .bus              (bus)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] base_of(input int k);
        return AW'(k * 32'h80000);
    endfunction

    // SDRAM controller model: serves every burst, pops len words, then finishes.
    initial begin
        bus.wr_burst_data_req = 1'b0;
        bus.wr_burst_finish   = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (rst_n && bus.wr_burst_req) begin
                int  blen;
                bit  cut;
                burst_t e;
                blen = int'(bus.wr_burst_len);
                burst_seq++;
                check_val("burst_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_val("burst_addr", 32'(bus.wr_burst_addr), 32'(e.addr));
                    check_val("burst_len", 32'(blen), 32'(e.len));
                end
                cut = 1'b0;
                for (int i = 0; i < blen; i++) begin
                    bus.wr_burst_data_req = 1'b1;
                    abort_srv = (burst_seq == abort_at) && (i == 10);
                    @(negedge mem_clk);
                    if (!rst_n) begin
                        cut = 1'b1;
                        break;
                    end
                end
                bus.wr_burst_data_req = 1'b0;
                abort_srv = 1'b0;
                if (!cut) begin
                    bus.wr_burst_finish = 1'b1;
                    @(negedge mem_clk);
                    bus.wr_burst_finish = 1'b0;
                    check_val("burst_req_drop", 32'(bus.wr_burst_req), 0);
                end
            end
        end
    end

    task automatic start_frame(input int len, input bit aut, input int idx, input int nexp, input int hold);
        int exp_idx, rem, b, n, aclr_len, held, guard;
        logic [AW-1:0] a;
        exp_idx = aut ? model_idx : idx;
        rem = len;
        a = base_of(exp_idx);
        n = 0;
        while (rem > 0 && n < nexp) begin
            b = (rem < BMAX) ? rem : BMAX;
            sb_q.push_back('{addr: a, len: b});
            a = a + AW'(b);
            rem -= b;
            n++;
        end
        burst_seq = 0;
        write_len = LW'(len);
        auto_index = aut;
        write_addr_index = 2'(idx);
        write_req = 1'b1;
        @(negedge mem_clk);
        check_val("ack_rise", 32'(write_req_ack), 1);
        check_val("aclr_rise", 32'(fifo_aclr), 1);
        check_val("busy_ack", 32'(busy), 1);
        check_val("cur_index", 32'(cur_index), 32'(exp_idx));
        aclr_len = 0;
        held = 1;
        guard = 0;
        while (fifo_aclr && guard < 100) begin
            aclr_len++;
            if (held >= hold) write_req = 1'b0;
            held++;
            guard++;
            @(negedge mem_clk);
        end
        write_req = 1'b0;
        check_val("aclr_min_len", 32'(aclr_len >= 4), 1);
        check_val("ack_fall", 32'(write_req_ack), 0);
    endtask

    task automatic wait_end(input bit exp_abort);
        int cyc;
        bit got_f, got_a;
        cyc = 0;
        got_f = write_finish;
        got_a = write_aborted;
        while (!got_f && !got_a && cyc < 20000) begin
            @(negedge mem_clk);
            cyc++;
            got_f = write_finish;
            got_a = write_aborted;
        end
        check_val("end_finish", 32'(got_f), 32'(!exp_abort));
        check_val("end_aborted", 32'(got_a), 32'(exp_abort));
        if (got_f && auto_index) model_idx = (model_idx + 1) % NB;
        @(negedge mem_clk);
        check_val("pulse_width", 32'(write_finish | write_aborted), 0);
        check_val("busy_idle", 32'(busy), 0);
        check_val("bursts_left", 32'(sb_q.size()), 0);
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < NB; k++) write_addr[k*AW +: AW] = base_of(k);

        repeat (3) @(negedge mem_clk);
        check_val("rst_ack", 32'(write_req_ack), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_breq", 32'(bus.wr_burst_req), 0);
        check_val("rst_aclr", 32'(fifo_aclr), 0);
        check_val("rst_index", 32'(cur_index), 0);
        check_val("rst_addr", 32'(bus.wr_burst_addr), 0);
        rst_n = 1'b1;
        @(negedge mem_clk);

        // 1024 words into buffer 2: four full bursts
        start_frame(1024, 1'b0, 2, 99, 1);
        wait_end(1'b0);
        // 600 words: 256, 256, 88
        start_frame(600, 1'b0, 2, 99, 1);
        wait_end(1'b0);

        // automatic rotation across five frames
        for (int f = 0; f < 5; f++) begin
            start_frame(16, 1'b1, 3, 99, 1);
            wait_end(1'b0);
        end

        // FIFO starvation holds the burst back until enough words are present
        rd_data_count = 16'd100;
        start_frame(256, 1'b0, 3, 99, 1);
        repeat (10) @(negedge mem_clk);
        check_val("starve_breq", 32'(bus.wr_burst_req), 0);
        rd_data_count = 16'd256;
        @(negedge mem_clk);
        check_val("fill_breq", 32'(bus.wr_burst_req), 1);
        wait_end(1'b0);
        rd_data_count = 16'd1024;

        // abort during the second of four bursts, rotation enabled
        abort_at = 2;
        start_frame(1024, 1'b1, 0, 2, 1);
        wait_end(1'b1);
        abort_at = -1;
        start_frame(16, 1'b1, 0, 99, 1);
        wait_end(1'b0);

        // abort while waiting for FIFO data
        rd_data_count = 16'd0;
        start_frame(64, 1'b0, 0, 0, 1);
        repeat (3) @(negedge mem_clk);
        abort_main = 1'b1;
        @(negedge mem_clk);
        abort_main = 1'b0;
        wait_end(1'b1);
        rd_data_count = 16'd1024;

        // asynchronous reset in the middle of a burst
        start_frame(1024, 1'b0, 1, 1, 1);
        cyc = 0;
        while (!bus.wr_burst_req && cyc < 50) begin
            @(negedge mem_clk);
            cyc++;
        end
        check_val("rst_test_breq", 32'(bus.wr_burst_req), 1);
        repeat (3) @(negedge mem_clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_breq", 32'(bus.wr_burst_req), 0);
        check_val("async_busy", 32'(busy), 0);
        check_val("async_index", 32'(cur_index), 0);
        check_val("async_addr", 32'(bus.wr_burst_addr), 0);
        sb_q.delete();
        model_idx = 0;
        @(negedge mem_clk);
        @(negedge mem_clk);
        rst_n = 1'b1;
        @(negedge mem_clk);
        // zero-length frame, request held two cycles
        start_frame(0, 1'b1, 2, 99, 2);
        wait_end(1'b0);
        check_val("zero_len_bursts", 32'(burst_seq), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
